q_update_engine: RTL
====================

Name: q_update_engine

Overview:
- Initiator side of the Q-table memory interface: sequences reads and writes to the Q-value BRAM (64 states x 4 actions, 8-bit entries, address {state[5:0], action[1:0]}).
- For one transition (s, a, r, s') it performs 1 read of Q(s,a) and 4 reads of row Q(s',0..3), computes max/argmax, applies the fixed-point Q-learning update and writes Q(s,a) back.
- Sits between the agent/environment controller (start/done handshake) and the Q-table BRAM, which has 1-cycle registered read latency.

Parameters:
- ADDR_WIDTH, 8, Q-table address width = STATE_WIDTH + ACTION_WIDTH
- STATE_WIDTH, 6, state index width
- ACTION_WIDTH, 2, action index width; row holds 2**ACTION_WIDTH = 4 entries
- DATA_WIDTH, 8, Q-value and reward width, signed two's complement
- ALPHA_SHIFT, 2, learning rate alpha = 2^-ALPHA_SHIFT
- GAMMA_SHIFT, 3, discount gamma = 1 - 2^-GAMMA_SHIFT

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous, active-high reset
- i_start  in  1  request; sampled only while o_busy=0
- i_state  in  STATE_WIDTH  current state s
- i_action  in  ACTION_WIDTH  action taken a
- i_reward  in  DATA_WIDTH  signed reward r
- i_next_state  in  STATE_WIDTH  next state s'
- i_terminal  in  1  s' terminal: target = r (no bootstrap)
- o_busy  out  1  update in progress
- o_done  out  1  1-cycle pulse, coincident with write
- o_best_action  out  ACTION_WIDTH  argmax over Q(s',*), valid from o_done until next start
- o_max_q  out  DATA_WIDTH  max over Q(s',*), same validity
- o_addr_r  out  ADDR_WIDTH  BRAM read address
- o_read_en  out  1  BRAM read enable
- i_q_data  in  DATA_WIDTH  BRAM read data, valid cycle after o_read_en
- o_addr_w  out  ADDR_WIDTH  BRAM write address
- o_write_en  out  1  BRAM write enable
- o_data  out  DATA_WIDTH  BRAM write data

Behaviour:
- Reset: i_rst synchronous, active-high; clock i_clk. All outputs 0, FSM to IDLE, internal registers 0. Reset mid-operation aborts immediately; no write is issued afterwards.
- FSM: IDLE -> READ -> DRAIN -> CALC -> WRITE -> IDLE.
- IDLE: o_busy=0. On edge with i_start=1, latch s, a, r, s', terminal; go READ; idx=0. i_start while o_busy=1 ignored.
- READ (cycles 1-5 after start edge): o_read_en=1; o_addr_r = {s,a} for idx 0, {s',idx-1} for idx 1..4. idx increments each cycle; after idx 4 go DRAIN.
- Capture: i_q_data is captured the cycle after each read. idx0 -> q_sa; idx1..4 -> running max/argmax, strict greater-than so ties keep lowest action index.
- DRAIN (cycle 6): o_read_en=0; capture last row entry.
- CALC (cycle 7): register q_new. Arithmetic uses 10-bit signed, arithmetic shifts (floor):
  - gmax = max - (max >>> GAMMA_SHIFT)
  - target = i_terminal ? r : r + gmax
  - delta = target - q_sa
  - q_new = q_sa + (delta >>> ALPHA_SHIFT), then narrowed to DATA_WIDTH (see feature).
- WRITE (cycle 8): o_write_en=1, o_addr_w={s,a}, o_data=q_new, o_done=1, o_busy still 1; o_max_q/o_best_action updated. Next cycle IDLE, o_busy=0; new start accepted in that cycle.
- o_read_en and o_write_en are never high in the same cycle.
- s'==s is legal: no write is pending during reads, so no hazard.
- Back-to-back updates: 9 cycles each (start edge to start edge).

Optional Feature:
- QUPD_SAT_EN defined: q_new saturates to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1] ([-128,127]).
- Undefined: q_new truncated to low DATA_WIDTH bits (two's complement wrap).

Test Plan:
- BRAM all 0, s=5,a=2,r=16,s'=6, not terminal -> write at cycle 8, addr 0x16, data 4; o_max_q=0, o_best_action=0 (tie -> lowest).
- Q(s,a)=40, row s'={10,80,20,5}, r=8 -> gmax=70, target=78, delta=38, write 49; o_best_action=1, o_max_q=80; read address sequence checked cycles 1-5.
- Same as above with i_terminal=1, r=-8 -> delta=-48, write 28.
- Q(s,a)=120, row max 127, r=127 -> raw 149: QUPD_SAT_EN writes 127 (0x7F); without macro writes -107 (0x95).
- Repeat i_start every cycle during an update -> exactly one write per 9 cycles, inputs latched only at accepted starts.
- Assert i_rst at cycle 4 of an update -> next cycle all outputs 0, o_write_en never asserted; fresh start then completes normally.

Source files
------------

// File: rtl/q_update_engine.sv
// Q-learning update engine: reads Q(s,a) and row Q(s',*) from the Q-table BRAM,
// computes max/argmax and the fixed-point update, writes Q(s,a) back.
// Optional: define QUPD_SAT_EN to saturate q_new instead of wrapping.
module q_update_engine #(
  parameter int ADDR_WIDTH   = 8,
  parameter int STATE_WIDTH  = 6,
  parameter int ACTION_WIDTH = 2,
  parameter int DATA_WIDTH   = 8,
  parameter int ALPHA_SHIFT  = 2,
  parameter int GAMMA_SHIFT  = 3
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic [STATE_WIDTH-1:0]  i_state,
  input  logic [ACTION_WIDTH-1:0] i_action,
  input  logic [DATA_WIDTH-1:0]   i_reward,
  input  logic [STATE_WIDTH-1:0]  i_next_state,
  input  logic                    i_terminal,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [ACTION_WIDTH-1:0] o_best_action,
  output logic [DATA_WIDTH-1:0]   o_max_q,
  output logic [ADDR_WIDTH-1:0]   o_addr_r,
  output logic                    o_read_en,
  input  logic [DATA_WIDTH-1:0]   i_q_data,
  output logic [ADDR_WIDTH-1:0]   o_addr_w,
  output logic                    o_write_en,
  output logic [DATA_WIDTH-1:0]   o_data
);

  localparam int CW = DATA_WIDTH + 2;
  localparam logic [ACTION_WIDTH:0] IDX_LAST = {1'b1, {ACTION_WIDTH{1'b0}}};
  localparam logic signed [CW-1:0] QMAX = CW'((2 ** (DATA_WIDTH - 1)) - 1);
  localparam logic signed [CW-1:0] QMIN = -QMAX - CW'(1);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_DRAIN, S_CALC, S_WRITE} state_t;

  state_t                   state_q, state_d;
  logic [ACTION_WIDTH:0]    idx_q, idx_d;
  logic [STATE_WIDTH-1:0]   s_q, sp_q;
  logic [ACTION_WIDTH-1:0]  a_q;
  logic signed [DATA_WIDTH-1:0] r_q;
  logic                     term_q;

  logic                     cap_vld_q, cap_first_q;
  logic [ACTION_WIDTH-1:0]  cap_act_q;
  logic signed [DATA_WIDTH-1:0] qsa_q, max_q;
  logic [ACTION_WIDTH-1:0]  arg_q;
  logic [DATA_WIDTH-1:0]    q_new_q, max_out_q;
  logic [ACTION_WIDTH-1:0]  best_out_q;

  logic [ACTION_WIDTH-1:0]  rd_act;
  logic signed [CW-1:0]     max_x, r_x, qsa_x, gmax, target, delta, sum;
  logic [DATA_WIDTH-1:0]    q_new_c;

  // idx 1..NROW reads row entry idx-1; idx==NROW wraps to the last action
  assign rd_act = idx_q[ACTION_WIDTH-1:0] - ACTION_WIDTH'(1);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      S_IDLE:  if (i_start) begin state_d = S_READ; idx_d = '0; end
      S_READ: begin
        idx_d = idx_q + (ACTION_WIDTH+1)'(1);
        if (idx_q == IDX_LAST) state_d = S_DRAIN;
      end
      S_DRAIN: state_d = S_CALC;
      S_CALC:  state_d = S_WRITE;
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    max_x  = CW'(max_q);
    r_x    = CW'(r_q);
    qsa_x  = CW'(qsa_q);
    gmax   = max_x - (max_x >>> GAMMA_SHIFT);
    target = term_q ? r_x : r_x + gmax;
    delta  = target - qsa_x;
    sum    = qsa_x + (delta >>> ALPHA_SHIFT);
`ifdef QUPD_SAT_EN
    if (sum > QMAX)      q_new_c = QMAX[DATA_WIDTH-1:0];
    else if (sum < QMIN) q_new_c = QMIN[DATA_WIDTH-1:0];
    else                 q_new_c = sum[DATA_WIDTH-1:0];
`else
    q_new_c = sum[DATA_WIDTH-1:0];
`endif
  end

`ifndef QUPD_SAT_EN
  logic unused_sat;
  assign unused_sat = ^{sum[CW-1:DATA_WIDTH], QMAX, QMIN};
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      s_q         <= '0;
      a_q         <= '0;
      r_q         <= '0;
      sp_q        <= '0;
      term_q      <= 1'b0;
      cap_vld_q   <= 1'b0;
      cap_first_q <= 1'b0;
      cap_act_q   <= '0;
      qsa_q       <= '0;
      max_q       <= '0;
      arg_q       <= '0;
      q_new_q     <= '0;
      max_out_q   <= '0;
      best_out_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (state_q == S_IDLE && i_start) begin
        s_q    <= i_state;
        a_q    <= i_action;
        r_q    <= i_reward;
        sp_q   <= i_next_state;
        term_q <= i_terminal;
      end
      // BRAM data lags the request by one cycle
      cap_vld_q   <= (state_q == S_READ);
      cap_first_q <= (idx_q == '0);
      cap_act_q   <= rd_act;
      if (cap_vld_q) begin
        if (cap_first_q) begin
          qsa_q <= i_q_data;
        end else if (cap_act_q == '0 || $signed(i_q_data) > max_q) begin
          max_q <= i_q_data;
          arg_q <= cap_act_q;
        end
      end
      if (state_q == S_CALC) begin
        q_new_q    <= q_new_c;
        max_out_q  <= max_q;
        best_out_q <= arg_q;
      end
    end
  end

  always_comb begin
    o_busy     = (state_q != S_IDLE);
    o_read_en  = 1'b0;
    o_addr_r   = '0;
    o_write_en = 1'b0;
    o_addr_w   = '0;
    o_data     = '0;
    o_done     = 1'b0;
    if (state_q == S_READ) begin
      o_read_en = 1'b1;
      o_addr_r  = (idx_q == '0) ? {s_q, a_q} : {sp_q, rd_act};
    end
    if (state_q == S_WRITE) begin
      o_write_en = 1'b1;
      o_addr_w   = {s_q, a_q};
      o_data     = q_new_q;
      o_done     = 1'b1;
    end
    o_max_q       = max_out_q;
    o_best_action = best_out_q;
  end

endmodule
